// File: rtl/robs_control_unit.sv
// Moore control FSM for the signed Robertson multiplier; drives the robs_datapath control word.
// Optional feature macro: ROBS_START_RESTART_EN (start while busy aborts and restarts at LOAD).
module robs_control_unit #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        zr,
  input  logic        zq,
  output logic [14:0] c,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    INIT,
    TEST,
    ADD_IS,
    ADD_WB,
    SH_LD,
    SH,
    SH_WB,
    FIN
  } state_t;

  state_t state, next;
  logic   addsub_q;

  // zq fires on counter % 8 == 0, so the datapath counter must start on a multiple of 8
  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_check
    $error("robs_control_unit: WIDTH must be a positive multiple of 8");
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addsub_q <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= next;
      if (state == ADD_IS)
        addsub_q <= ~zq;
      done <= (state == FIN) && (next == IDLE);
    end
  end

  // The final iteration handles the sign bit, so ADD_IS subtracts when zq is set
  always_comb begin
    next = state;
    c    = '0;
    case (state)
      IDLE: begin
        if (start)
          next = LOAD;
      end
      LOAD: begin
        c[3:0] = 4'hF;
        next   = INIT;
      end
      INIT: begin
        c[8] = 1'b1;
        c[9] = 1'b1;
        next = TEST;
      end
      TEST: begin
        c[13] = 1'b1;
        next  = zr ? SH_LD : ADD_IS;
      end
      ADD_IS: begin
        c[10] = ~zq;
        next  = ADD_WB;
      end
      ADD_WB: begin
        c[10]  = addsub_q;
        c[5:4] = 2'd2;
        c[8]   = 1'b1;
        next   = SH_LD;
      end
      SH_LD: begin
        c[12] = 1'b1;
        next  = SH;
      end
      SH: begin
        c[11] = 1'b1;
        next  = SH_WB;
      end
      SH_WB: begin
        c[5:4] = 2'd1;
        c[6]   = 1'b1;
        c[8]   = 1'b1;
        c[9]   = 1'b1;
        next   = zq ? FIN : TEST;
      end
      FIN: begin
        c[14] = 1'b1;
        c[7]  = 1'b1;
        c[3]  = 1'b1;
        next  = IDLE;
      end
      default: next = IDLE;
    endcase
`ifdef ROBS_START_RESTART_EN
    if (start && state != IDLE && state != LOAD)
      next = LOAD;
`else
`endif
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_robs_control_unit.sv
// Directed bench for robs_control_unit with a behavioural Robertson datapath attached.
// Honours ROBS_START_RESTART_EN for the start-while-busy scenario.
module tb_robs_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        zr;
  logic        zq;
  logic [14:0] c;
  logic        busy;
  logic        done;

  logic [7:0] mcand, mplier;
  int n_cmp = 0;
  int n_bad = 0;

  robs_control_unit #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .zr   (zr),
    .zq   (zq),
    .c    (c),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Datapath model; R high carries a guard bit so -128 * -128 does not overflow
  logic [7:0]        dp_y, dp_a, dp_x, dp_rlo;
  logic signed [8:0] dp_rhi;
  logic [16:0]       dp_sr;
  logic [3:0]        dp_cnt;
  logic signed [8:0] alu;

  assign alu = c[10] ? dp_rhi + $signed({dp_y[7], dp_y}) : dp_rhi - $signed({dp_y[7], dp_y});
  assign zr  = ~dp_rlo[0];
  assign zq  = (dp_cnt[2:0] == 3'd0);

  always @(posedge clk) begin
    if (c[0]) dp_y <= mcand;
    if (c[1]) dp_cnt <= 4'd8;
    else if (c[13]) dp_cnt <= dp_cnt - 4'd1;
    if (c[2]) dp_a <= 8'd0;
    else if (c[14]) dp_a <= dp_rhi[7:0];
    if (c[3]) dp_x <= c[7] ? dp_rlo : mplier;
    if (c[8]) begin
      case (c[5:4])
        2'd0:    dp_rhi <= $signed({dp_a[7], dp_a});
        2'd1:    dp_rhi <= $signed(dp_sr[16:8]);
        default: dp_rhi <= alu;
      endcase
    end
    if (c[9]) dp_rlo <= c[6] ? dp_sr[7:0] : dp_x;
    if (c[12]) dp_sr <= {dp_rhi, dp_rlo};
    else if (c[11]) dp_sr <= {dp_sr[16], dp_sr[16:1]};
  end

  // Observes ADD_IS / ADD_WB / TEST / done activity per operation
  int   add_is_cnt, sub_cnt, sub_iter, iter_cnt, wb_bad, done_cnt;
  logic last_is_c10;
  logic [14:0] c_log [0:255];

  always @(negedge clk) begin
    if (!reset) begin
      if (c == 15'h2000) iter_cnt++;
      if (busy && ((c & 15'h7BFF) == 15'h0000)) begin
        add_is_cnt++;
        last_is_c10 = c[10];
        if (!c[10]) begin
          sub_cnt++;
          sub_iter = iter_cnt;
        end
      end
      if (c[8] && c[5:4] == 2'd2 && c[10] !== last_is_c10) wb_bad++;
      if (done) done_cnt++;
    end
  end

  task automatic clear_mon();
    add_is_cnt = 0; sub_cnt = 0; sub_iter = 0; iter_cnt = 0; wb_bad = 0; done_cnt = 0;
    last_is_c10 = 1'b1;
  endtask

  task automatic do_mult(input logic [7:0] y, input logic [7:0] x, output int lat, output logic [15:0] prod);
    @(posedge clk); #2;
    mcand = y; mplier = x; clear_mon(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    prod = 'x;
    for (int n = 1; n <= 200; n++) begin
      c_log[n] = c;
      if (done) begin
        lat = n;
        prod = {dp_a, dp_x};
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mcand = 8'd0; mplier = 8'd0;
    #1 reset = 1'b1;
    #2;
    n_cmp++; if (c !== 15'h0) begin n_bad++; $display("[TB] FAIL reset_c: got %h want 0000", c); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
    n_cmp++; if (c !== 15'h0) begin n_bad++; $display("[TB] FAIL idle_c: got %h want 0000", c); end
  endtask

  task automatic test_zero_multiplier();
    int lat; logic [15:0] prod;
    do_mult(8'd3, 8'h00, lat, prod);
    n_cmp++; if (lat !== 36) begin n_bad++; $display("[TB] FAIL zero_latency: got %0d want 36", lat); end
    n_cmp++; if (prod !== 16'h0000) begin n_bad++; $display("[TB] FAIL zero_product: got %h want 0000", prod); end
    n_cmp++; if (c_log[1] !== 15'h000F) begin n_bad++; $display("[TB] FAIL load_word: got %h want 000f", c_log[1]); end
    n_cmp++; if (c_log[2] !== 15'h0300) begin n_bad++; $display("[TB] FAIL init_word: got %h want 0300", c_log[2]); end
    n_cmp++; if (c_log[3] !== 15'h2000) begin n_bad++; $display("[TB] FAIL test_word: got %h want 2000", c_log[3]); end
    n_cmp++; if (c_log[4] !== 15'h1000) begin n_bad++; $display("[TB] FAIL shld_word: got %h want 1000", c_log[4]); end
    n_cmp++; if (c_log[5] !== 15'h0800) begin n_bad++; $display("[TB] FAIL sh_word: got %h want 0800", c_log[5]); end
    n_cmp++; if (c_log[6] !== 15'h0350) begin n_bad++; $display("[TB] FAIL shwb_word: got %h want 0350", c_log[6]); end
    n_cmp++; if (c_log[35] !== 15'h4088) begin n_bad++; $display("[TB] FAIL fin_word: got %h want 4088", c_log[35]); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL zero_done_pulse: got %b want 0", done); end
    n_cmp++; if (add_is_cnt !== 0) begin n_bad++; $display("[TB] FAIL zero_adds: got %0d want 0", add_is_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL zero_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_positive();
    int lat; logic [15:0] prod;
    do_mult(8'd5, 8'd3, lat, prod);
    n_cmp++; if (lat !== 40) begin n_bad++; $display("[TB] FAIL pos_latency: got %0d want 40", lat); end
    n_cmp++; if (prod !== 16'h000F) begin n_bad++; $display("[TB] FAIL pos_product: got %h want 000f", prod); end
    n_cmp++; if (c_log[5] !== 15'h0520) begin n_bad++; $display("[TB] FAIL addwb_word: got %h want 0520", c_log[5]); end
    @(posedge clk); #1;
    n_cmp++; if (add_is_cnt !== 2) begin n_bad++; $display("[TB] FAIL pos_adds: got %0d want 2", add_is_cnt); end
    n_cmp++; if (sub_cnt !== 0) begin n_bad++; $display("[TB] FAIL pos_subs: got %0d want 0", sub_cnt); end
    n_cmp++; if (wb_bad !== 0) begin n_bad++; $display("[TB] FAIL pos_wb_hold: got %0d want 0", wb_bad); end
  endtask

  task automatic test_sign_subtract();
    int lat; logic [15:0] prod;
    do_mult(8'd7, 8'hFF, lat, prod);
    n_cmp++; if (lat !== 52) begin n_bad++; $display("[TB] FAIL sign_latency: got %0d want 52", lat); end
    n_cmp++; if (prod !== 16'hFFF9) begin n_bad++; $display("[TB] FAIL sign_product: got %h want fff9", prod); end
    @(posedge clk); #1;
    n_cmp++; if (add_is_cnt !== 8) begin n_bad++; $display("[TB] FAIL sign_adds: got %0d want 8", add_is_cnt); end
    n_cmp++; if (sub_cnt !== 1) begin n_bad++; $display("[TB] FAIL sign_subs: got %0d want 1", sub_cnt); end
    n_cmp++; if (sub_iter !== 8) begin n_bad++; $display("[TB] FAIL sign_sub_iter: got %0d want 8", sub_iter); end
    n_cmp++; if (wb_bad !== 0) begin n_bad++; $display("[TB] FAIL sign_wb_hold: got %0d want 0", wb_bad); end
  endtask

  task automatic test_extreme();
    int lat; logic [15:0] prod;
    do_mult(8'h80, 8'h80, lat, prod);
    n_cmp++; if (lat !== 38) begin n_bad++; $display("[TB] FAIL ext_latency: got %0d want 38", lat); end
    n_cmp++; if (prod !== 16'h4000) begin n_bad++; $display("[TB] FAIL ext_product: got %h want 4000", prod); end
    @(posedge clk); #1;
    n_cmp++; if (add_is_cnt !== 1) begin n_bad++; $display("[TB] FAIL ext_adds: got %0d want 1", add_is_cnt); end
    n_cmp++; if (sub_cnt !== 1) begin n_bad++; $display("[TB] FAIL ext_subs: got %0d want 1", sub_cnt); end
  endtask

  task automatic test_reset_in_add();
    int lat; logic [15:0] prod; int wb_cycle;
    @(posedge clk); #2;
    mcand = 8'd5; mplier = 8'd3; clear_mon(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wb_cycle = -1;
    for (int n = 1; n <= 60; n++) begin
      if (c[8] && c[5:4] == 2'd2) begin
        wb_cycle = n;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (wb_cycle !== 5) begin n_bad++; $display("[TB] FAIL addwb_cycle: got %0d want 5", wb_cycle); end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (c !== 15'h0) begin n_bad++; $display("[TB] FAIL midreset_c: got %h want 0000", c); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_done: got %b want 0", done); end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL postreset_busy: got %b want 0", busy); end
    do_mult(8'd5, 8'd3, lat, prod);
    n_cmp++; if (lat !== 40) begin n_bad++; $display("[TB] FAIL rerun_latency: got %0d want 40", lat); end
    n_cmp++; if (prod !== 16'h000F) begin n_bad++; $display("[TB] FAIL rerun_product: got %h want 000f", prod); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_in_test();
    int lat; int test_cycle; int exp_lat;
`ifdef ROBS_START_RESTART_EN
    exp_lat = 40;
`else
    exp_lat = 37;
`endif
    @(posedge clk); #2;
    mcand = 8'd5; mplier = 8'd3; clear_mon(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    test_cycle = -1;
    for (int n = 1; n <= 60; n++) begin
      if (c == 15'h2000) begin
        test_cycle = n;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (test_cycle !== 3) begin n_bad++; $display("[TB] FAIL test_cycle: got %0d want 3", test_cycle); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("[TB] FAIL busy_start_latency: got %0d want %0d", lat, exp_lat); end
    n_cmp++; if ({dp_a, dp_x} !== 16'h000F) begin n_bad++; $display("[TB] FAIL busy_start_product: got %h want 000f", {dp_a, dp_x}); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL busy_start_pulse: got %b want 0", done); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("[TB] FAIL busy_start_dones: got %0d want 1", done_cnt); end
    n_cmp++; if (add_is_cnt !== 2) begin n_bad++; $display("[TB] FAIL busy_start_adds: got %0d want 2", add_is_cnt); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_zero_multiplier();
    test_positive();
    test_sign_subtract();
    test_extreme();
    test_reset_in_add();
    test_start_in_test();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
